// File: rtl/mul_div_seq_if.sv
// Request/response bundle for the sequential RISC-V M-extension multiply/divide unit.
// The requester drives the master side; mul_div_seq sits on the slave side.
interface mul_div_seq_if #(
    parameter int XLEN = 64
) ();
    logic            START;
    logic [2:0]      OP;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            KILL;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;
    logic            DIV_ZERO;

    modport master (
        output START, OP, A, B, KILL,
        input  BUSY, DONE, RESULT, DIV_ZERO
    );

    modport slave (
        input  START, OP, A, B, KILL,
        output BUSY, DONE, RESULT, DIV_ZERO
    );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative RV M-extension unit: one radix-2 shift-add / restoring shift-subtract step
// per cycle on operand magnitudes, followed by a single sign-fix cycle.
module mul_div_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    mul_div_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              div_zero_q, div_zero_d;

    // Operand classification at accept time
    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            by_zero, ovf;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN-1:0]   div_try;
    logic              div_qbit;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        // rs1 is signed for every op except MULHU/DIVU/REMU; rs2 only for MUL/MULH/DIV/REM
        sgn_a   = bus.OP[2] ? ~bus.OP[0] : ~(bus.OP[1] & bus.OP[0]);
        sgn_b   = bus.OP[2] ? ~bus.OP[0] : ~bus.OP[1];
        a_neg   = sgn_a & bus.A[XLEN-1];
        b_neg   = sgn_b & bus.B[XLEN-1];
        a_mag   = a_neg ? (~bus.A + 1'b1) : bus.A;
        b_mag   = b_neg ? (~bus.B + 1'b1) : bus.B;
        by_zero = bus.OP[2] & (bus.B == '0);
        ovf     = bus.OP[2] & ~bus.OP[0] & (bus.A == MIN_NEG) & (bus.B == ALL_ONES);

        // Multiply: {acc,lo} shifts right, multiplier bits consumed from lo[0]
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});

        // Divide: {acc,lo} shifts left, quotient bits enter at lo[0].
        // acc < divisor always holds, so a successful trial fits in XLEN bits.
        div_sh   = {acc_q, lo_q[XLEN-1]};
        div_qbit = (div_sh >= {1'b0, opb_q});
        div_try  = div_sh[XLEN-1:0] - opb_q;

        prod     = {acc_q, lo_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        neg_d      = neg_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.KILL) begin
                    op_d  = bus.OP;
                    cnt_d = '0;
                    if (by_zero) begin
                        result_d   = bus.OP[1] ? bus.A : ALL_ONES;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (ovf) begin
                        result_d   = bus.OP[1] ? '0 : MIN_NEG;
                        div_zero_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        acc_d   = '0;
                        lo_d    = a_mag;
                        opb_d   = b_mag;
                        // REM takes the dividend's sign; everything else the xor of both
                        neg_d   = (bus.OP[2] & bus.OP[1]) ? a_neg : (a_neg ^ b_neg);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.KILL) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        acc_d = div_qbit ? div_try : div_sh[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], div_qbit};
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.KILL) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2])
                        result_d = op_q[1] ? rem_fix : quo_fix;
                    else
                        result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                        : prod_fix[2*XLEN-1:XLEN];
                    div_zero_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            opb_q      <= opb_d;
            neg_q      <= neg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.RESULT   = result_q;
    assign bus.DIV_ZERO = div_zero_q;

endmodule
